ctrl_conv_read: RTL and testbench

- Downstream consumer of the input-load stage in the 1-D CNN accelerator.
- Once the x (input) memory and f (filter) memory are both loaded, it sequences reads from them and computes each valid-window dot product with an internal MAC.
- Each result is presented on an AXI-style master valid/ready output.
- After the last window it pulses a release signal so the write-side controllers re-arm for the next vector.

---
 rtl/ctrl_conv_read.sv | 129 ++++++++++++
 tb/tb_ctrl_conv_read.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_conv_read.sv
// Read-side sequencer for the 1-D convolution: walks every valid window of x
// against the filter, accumulates the dot product and hands it out over valid/ready.
module ctrl_conv_read #(
  parameter int X_SIZE       = 8,
  parameter int F_SIZE       = 4,
  parameter int X_ADDR_WIDTH = 3,
  parameter int F_ADDR_WIDTH = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_WIDTH    = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        x_loaded,
  input  logic                        f_loaded,
  input  logic signed [DATA_WIDTH-1:0] x_data,
  input  logic signed [DATA_WIDTH-1:0] f_data,
  output logic [X_ADDR_WIDTH-1:0]     x_addr,
  output logic [F_ADDR_WIDTH-1:0]     f_addr,
  output logic                        rd_en,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        mem_release
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [X_ADDR_WIDTH-1:0] J_LAST = X_ADDR_WIDTH'(X_SIZE - F_SIZE);
  localparam logic [F_ADDR_WIDTH-1:0] K_LAST = F_ADDR_WIDTH'(F_SIZE - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [X_ADDR_WIDTH-1:0]     j_q, j_d;
  logic [F_ADDR_WIDTH-1:0]     k_q, k_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] m_data_q, m_data_d;
  // Read data lags its address by one cycle; these track which tap is landing.
  logic                        tap_vld_q, tap_vld_d;
  logic                        tap_first_q, tap_first_d;

  logic signed [PW-1:0]        prod;
  logic signed [OUT_WIDTH-1:0] prod_ext;
  logic signed [OUT_WIDTH-1:0] sum;

  always_comb begin
    prod     = PW'(x_data) * PW'(f_data);
    prod_ext = {{(OUT_WIDTH-PW){prod[PW-1]}}, prod};
    // Tap 0 restarts the sum so nothing leaks between windows.
    sum      = tap_first_q ? prod_ext : acc_q + prod_ext;
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    m_data_d    = m_data_q;
    tap_vld_d   = 1'b0;
    tap_first_d = 1'b0;
    rd_en       = 1'b0;
    m_valid     = 1'b0;
    mem_release = 1'b0;
    x_addr      = j_q + X_ADDR_WIDTH'(k_q);
    f_addr      = k_q;

    if (tap_vld_q) acc_d = sum;

    case (state_q)
      IDLE: begin
        if (x_loaded && f_loaded) state_d = READ;
      end
      READ: begin
        rd_en       = 1'b1;
        tap_vld_d   = 1'b1;
        tap_first_d = (k_q == '0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        m_data_d = sum;
        state_d  = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (j_q == J_LAST) begin
            state_d = DONE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        mem_release = 1'b1;
        j_d         = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      m_data_q    <= '0;
      tap_vld_q   <= 1'b0;
      tap_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      m_data_q    <= m_data_d;
      tap_vld_q   <= tap_vld_d;
      tap_first_q <= tap_first_d;
    end
  end

  assign m_data = m_data_q;

endmodule

// File: tb/tb_ctrl_conv_read.sv
// Directed bench for ctrl_conv_read: behavioural x/f memories with 1-cycle read
// latency, hand-computed window sums, backpressure, start gating and abort.
module tb_ctrl_conv_read;

  logic              clk = 1'b0;
  logic              reset;
  logic              x_loaded, f_loaded, m_ready;
  logic signed [7:0] x_data = '0;
  logic signed [7:0] f_data = '0;
  logic [2:0]        x_addr;
  logic [1:0]        f_addr;
  logic              rd_en, m_valid, mem_release;
  logic signed [17:0] m_data;

  logic signed [7:0] x_mem [8];
  logic signed [7:0] f_mem [4];
  int exp_v [5];
  int n_tests = 0;
  int n_fail  = 0;
  int rel_cnt = 0;

  always #5 clk = ~clk;

  ctrl_conv_read #(
    .X_SIZE(8), .F_SIZE(4), .X_ADDR_WIDTH(3), .F_ADDR_WIDTH(2),
    .DATA_WIDTH(8), .OUT_WIDTH(18)
  ) dut (
    .clk(clk), .reset(reset), .x_loaded(x_loaded), .f_loaded(f_loaded),
    .x_data(x_data), .f_data(f_data), .x_addr(x_addr), .f_addr(f_addr),
    .rd_en(rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mem_release(mem_release)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= x_mem[x_addr];
      f_data <= f_mem[f_addr];
    end
    if (mem_release) rel_cnt <= rel_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_mem(input int xs [8], input int fs [4], input int es [5]);
    for (int i = 0; i < 8; i++) x_mem[i] = 8'(xs[i]);
    for (int i = 0; i < 4; i++) f_mem[i] = 8'(fs[i]);
    for (int i = 0; i < 5; i++) exp_v[i] = es[i];
  endtask

  // One vector: optional x-only gating, backpressure on result bp_idx,
  // reset abort on result rst_idx, loaded flags held high into the run.
  task automatic run_vec(input string nm, input bit gate, input int bp_idx,
                         input int rst_idx, input bit hold);
    int cyc;
    int rel0;
    rel0    = rel_cnt;
    m_ready = 1'b1;
    @(negedge clk);
    if (gate) begin
      x_loaded = 1'b1;
      repeat (10) begin
        @(negedge clk);
        check({nm, ".gate_rd_en"}, int'(rd_en), 0);
      end
    end
    x_loaded = 1'b1;
    f_loaded = 1'b1;
    @(negedge clk);
    if (!hold) begin
      x_loaded = 1'b0;
      f_loaded = 1'b0;
    end
    check({nm, ".rd_en0"}, int'(rd_en), 1);
    check({nm, ".x_addr0"}, int'(x_addr), 0);
    check({nm, ".f_addr0"}, int'(f_addr), 0);
    for (int r = 0; r < 5; r++) begin
      cyc = 1;
      while (!m_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check({nm, ".latency"}, cyc, 6);
      check({nm, ".m_data"}, int'(m_data), exp_v[r]);
      if (r == 2) begin
        x_loaded = 1'b0;
        f_loaded = 1'b0;
      end
      if (r == rst_idx) begin
        reset   = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check({nm, ".abort_valid"}, int'(m_valid), 0);
        check({nm, ".abort_rd_en"}, int'(rd_en), 0);
        check({nm, ".abort_data"}, int'(m_data), 0);
        repeat (3) @(negedge clk);
        check({nm, ".abort_idle"}, int'(rd_en), 0);
        check({nm, ".abort_release"}, rel_cnt, rel0);
        m_ready = 1'b1;
        return;
      end
      if (r == bp_idx) begin
        m_ready = 1'b0;
        repeat (7) begin
          @(negedge clk);
          check({nm, ".hold_valid"}, int'(m_valid), 1);
          check({nm, ".hold_data"}, int'(m_data), exp_v[r]);
          check({nm, ".hold_rd_en"}, int'(rd_en), 0);
        end
        m_ready = 1'b1;
      end
      @(negedge clk);
    end
    check({nm, ".release_hi"}, int'(mem_release), 1);
    @(negedge clk);
    check({nm, ".release_lo"}, int'(mem_release), 0);
    check({nm, ".idle_valid"}, int'(m_valid), 0);
    check({nm, ".release_cnt"}, rel_cnt, rel0 + 1);
  endtask

  initial begin
    reset    = 1'b1;
    x_loaded = 1'b0;
    f_loaded = 1'b0;
    m_ready  = 1'b0;
    set_mem('{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 1, 1, 1}, '{10, 14, 18, 22, 26});
    repeat (2) @(negedge clk);
    check("rst.m_valid", int'(m_valid), 0);
    check("rst.m_data", int'(m_data), 0);
    check("rst.rd_en", int'(rd_en), 0);
    check("rst.mem_release", int'(mem_release), 0);
    check("rst.x_addr", int'(x_addr), 0);
    check("rst.f_addr", int'(f_addr), 0);
    reset = 1'b0;

    run_vec("basic", 1'b0, -1, -1, 1'b0);

    set_mem('{-1, 2, -3, 4, -5, 6, -7, 8}, '{1, -1, 1, -1}, '{-10, 14, -18, 22, -26});
    run_vec("signed", 1'b0, -1, -1, 1'b1);

    set_mem('{-128, -128, -128, -128, -128, -128, -128, -128}, '{-128, -128, -128, -128},
            '{65536, 65536, 65536, 65536, 65536});
    run_vec("worst", 1'b0, -1, -1, 1'b0);

    set_mem('{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 1, 1, 1}, '{10, 14, 18, 22, 26});
    run_vec("backpressure", 1'b0, 1, -1, 1'b0);
    run_vec("gating", 1'b1, -1, -1, 1'b0);
    run_vec("abort", 1'b0, -1, 2, 1'b0);
    run_vec("restart", 1'b0, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
